// File: rtl/reg_transfer_controller_pkg.sv
// Shared definitions for the register-transfer controller.
// Holds the command operation encodings, the R0..R7 register selector
// constants and a small helper that classifies operations. The controller
// and its testbench both import this package.
package reg_transfer_controller_pkg;

    // Command operation encodings
    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_SWAP = 2'b01;
    localparam logic [1:0] OP_LDI  = 2'b10;
    localparam logic [1:0] OP_RD   = 2'b11;

    // Register-file selector constants
    localparam logic [2:0] R0 = 3'd0;
    localparam logic [2:0] R1 = 3'd1;
    localparam logic [2:0] R2 = 3'd2;
    localparam logic [2:0] R3 = 3'd3;
    localparam logic [2:0] R4 = 3'd4;
    localparam logic [2:0] R5 = 3'd5;
    localparam logic [2:0] R6 = 3'd6;
    localparam logic [2:0] R7 = 3'd7;

    // True for every operation that starts by reading the source register.
    function automatic logic op_reads_rf(input logic [1:0] op);
        return (op != OP_LDI);
    endfunction

endpackage

// File: rtl/reg_transfer_controller_if.sv
// Command / response handshake bundle of the register-transfer controller.
//   cmd_valid/cmd_ready  : command offer and accept
//   cmd_op/rd/rs/imm     : command fields (2/3/3/8 bits)
//   rsp_valid/rsp_ready  : read-result handshake
//   rsp_data             : 8-bit read result
// master = command issuer / response consumer, slave = the controller.
interface reg_transfer_controller_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_rd;
    logic [2:0] cmd_rs;
    logic [7:0] cmd_imm;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/reg_transfer_controller.sv
// Register-transfer controller: sequences MOV / SWAP / LDI / RD commands
// against an external register file whose read port has one clock of
// latency (rf_rdata reflects rf_src_sel one clock after it is applied).
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   bus          : command/response handshake (slave side)
//   done         : one-cycle pulse when MOV/SWAP/LDI completes
//   busy         : high whenever the controller is not idle
//   rf_src_sel   : register-file read selector (held outside read states)
//   rf_dst_sel   : register-file write selector (held outside write states)
//   rf_dst_we    : register-file write qualifier, forced low during reset
//   rf_wdata     : register-file write data (held outside write states)
//   rf_rdata     : register-file read data
module reg_transfer_controller
    import reg_transfer_controller_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    reg_transfer_controller_if.slave bus,
    output logic                     done,
    output logic                     busy,
    output logic [2:0]               rf_src_sel,
    output logic [2:0]               rf_dst_sel,
    output logic                     rf_dst_we,
    output logic [7:0]               rf_wdata,
    input  logic [7:0]               rf_rdata
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_RD_A  = 4'd1;
    localparam logic [3:0] S_CAP_A = 4'd2;
    localparam logic [3:0] S_RD_B  = 4'd3;
    localparam logic [3:0] S_CAP_B = 4'd4;
    localparam logic [3:0] S_WR_A  = 4'd5;
    localparam logic [3:0] S_WR_B  = 4'd6;
    localparam logic [3:0] S_RESP  = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    logic [3:0] state_r;
    logic [3:0] state_nxt_s;
    logic       accept_s;
    logic [1:0] op_r;
    logic [2:0] rd_r;
    logic [2:0] rs_r;
    logic [7:0] tmp_a_r;
    logic [7:0] tmp_b_r;
    logic [7:0] rsp_data_r;

    assign accept_s = bus.cmd_valid && (state_r == S_IDLE);

    // Next-state selection for the command sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (op_reads_rf(bus.cmd_op)) begin
                        state_nxt_s = S_RD_A;
                    end else begin
                        state_nxt_s = S_WR_A;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RD_A:  state_nxt_s = S_CAP_A;
            S_CAP_A: begin
                case (op_r)
                    OP_SWAP: state_nxt_s = S_RD_B;
                    OP_RD:   state_nxt_s = S_RESP;
                    default: state_nxt_s = S_WR_A;
                endcase
            end
            S_RD_B:  state_nxt_s = S_CAP_B;
            S_CAP_B: state_nxt_s = S_WR_A;
            S_WR_A: begin
                if (op_r == OP_SWAP) begin
                    state_nxt_s = S_WR_B;
                end else begin
                    state_nxt_s = S_DONE;
                end
            end
            S_WR_B:  state_nxt_s = S_DONE;
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RESP;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register and captured command fields
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            op_r    <= 2'b00;
            rd_r    <= 3'd0;
            rs_r    <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                op_r <= bus.cmd_op;
                rd_r <= bus.cmd_rd;
                rs_r <= bus.cmd_rs;
            end
        end
    end

    // Read selector and read-data capture registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_src_sel <= 3'd0;
            tmp_a_r    <= 8'h00;
            tmp_b_r    <= 8'h00;
            rsp_data_r <= 8'h00;
        end else begin
            // Selector is loaded on the edge entering RD_A / RD_B so the
            // register file sees it for the whole read state; LDI never reads.
            if (accept_s && op_reads_rf(bus.cmd_op)) begin
                rf_src_sel <= bus.cmd_rs;
            end
            if ((state_r == S_CAP_A) && (op_r == OP_SWAP)) begin
                rf_src_sel <= rd_r;
            end
            if (state_r == S_CAP_A) begin
                tmp_a_r <= rf_rdata;
            end
            if (state_r == S_CAP_B) begin
                tmp_b_r <= rf_rdata;
            end
            // RESP data is the value captured into tmp_a in the same edge.
            if ((state_r == S_CAP_A) && (op_r == OP_RD)) begin
                rsp_data_r <= rf_rdata;
            end
        end
    end

    // Write selector and write data, loaded on the edge entering a write state
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_dst_sel <= 3'd0;
            rf_wdata   <= 8'h00;
        end else begin
            // LDI writes in the cycle right after accept, so the immediate
            // goes straight into the write-data register at the accept edge.
            if (accept_s && (bus.cmd_op == OP_LDI)) begin
                rf_dst_sel <= bus.cmd_rd;
                rf_wdata   <= bus.cmd_imm;
            end
            // MOV: rf_rdata is the value being latched into tmp_a this edge.
            if ((state_r == S_CAP_A) && (op_r == OP_MOV)) begin
                rf_dst_sel <= rd_r;
                rf_wdata   <= rf_rdata;
            end
            if (state_r == S_CAP_B) begin
                rf_dst_sel <= rd_r;
                rf_wdata   <= tmp_a_r;
            end
            if ((state_r == S_WR_A) && (op_r == OP_SWAP)) begin
                rf_dst_sel <= rs_r;
                rf_wdata   <= tmp_b_r;
            end
        end
    end

    // Status and handshake outputs decoded from the state register
    assign bus.cmd_ready = (state_r == S_IDLE);
    assign bus.rsp_valid = (state_r == S_RESP);
    assign bus.rsp_data  = rsp_data_r;
    assign done          = (state_r == S_DONE);
    assign busy          = (state_r != S_IDLE);
    // Reset gating keeps an in-flight write from reaching the register file.
    assign rf_dst_we     = ((state_r == S_WR_A) || (state_r == S_WR_B)) && !reset;

endmodule
